// File: rtl/bird_sprite_renderer_if.sv
// Pixel-stream, bird-pose, sprite-ROM and composited-pixel signals of the bird sprite renderer.
// master drives the pixel/pose stream and ROM data; slave is the renderer itself.
interface bird_sprite_renderer_if #(
  parameter int COLOR_W = 24,
  parameter int ROM_AW  = 14
);
  logic               frame_start;
  logic               pix_valid;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic [31:0]        birdY;
  logic [1:0]         bird_state;
  logic [1:0]         bird_angle;
  logic [3:0]         game_state;
  logic [ROM_AW-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic               out_valid;
  logic               bird_opaque;
  logic [COLOR_W-1:0] bird_rgb;

  modport master (
    output frame_start, pix_valid, pix_x, pix_y, birdY, bird_state, bird_angle,
           game_state, rom_data,
    input  rom_addr, out_valid, bird_opaque, bird_rgb
  );

  modport slave (
    input  frame_start, pix_valid, pix_x, pix_y, birdY, bird_state, bird_angle,
           game_state, rom_data,
    output rom_addr, out_valid, bird_opaque, bird_rgb
  );
endinterface

// File: rtl/bird_sprite_renderer.sv
// Latches the bird pose once per frame and maps in-box pixels onto the sprite ROM.
// Latency 3 cycles, 1 pixel/cycle; no backpressure, the pipeline never stalls.
module bird_sprite_renderer #(
  parameter int                 BIRD_SIZE_X = 34,
  parameter int                 BIRD_SIZE_Y = 24,
  parameter int                 BIRD_X      = 100,
  parameter int                 V_ACTIVE    = 480,
  parameter int                 COLOR_W     = 24,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 24'hFF00FF,
  parameter int                 ROM_AW      = 14,
  parameter int                 BLINK_LOG2  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bird_sprite_renderer_if.slave  bus
);

  localparam logic [3:0] GS_PAUSE = 4'b0100;
  localparam logic [3:0] GS_END   = 4'b1000;
  localparam int         Y_MAX    = V_ACTIVE - BIRD_SIZE_Y;

  logic [9:0]          lat_y;
  logic [1:0]          lat_state;
  logic [1:0]          lat_angle;
  logic [9:0]          y_clamp;
  logic [1:0]          state_map;
  logic [1:0]          angle_map;
  logic [BLINK_LOG2:0] frame_cnt;
  logic                hidden;
  logic                in_box;
  logic                s2_hit;
  logic [ROM_AW-1:0]   col;
  logic [ROM_AW-1:0]   row;
  logic [ROM_AW-1:0]   pose_idx;
  logic [ROM_AW-1:0]   addr_nxt;
  logic                s1_valid;
  logic                s1_in_box;
  logic                s2_valid;
  logic                s2_in_box;

  // A negative birdY means the bird flew above the screen; pin it to the top line.
  always_comb begin
    if (bus.birdY[31])
      y_clamp = '0;
    else if (bus.birdY > 32'(Y_MAX))
      y_clamp = 10'(Y_MAX);
    else
      y_clamp = bus.birdY[9:0];
    state_map = (bus.bird_state == 2'd3) ? 2'd0 : bus.bird_state;
    angle_map = (bus.bird_angle == 2'd3) ? 2'd0 : bus.bird_angle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_y     <= 10'((V_ACTIVE - BIRD_SIZE_Y) / 2);
      lat_state <= 2'd0;
      lat_angle <= 2'd0;
    end else if (bus.frame_start && (bus.game_state != GS_PAUSE)) begin
      lat_y     <= y_clamp;
      lat_state <= state_map;
      lat_angle <= angle_map;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt <= '0;
    else if (bus.game_state != GS_END)
      frame_cnt <= '0;
    else if (bus.frame_start)
      frame_cnt <= frame_cnt + 1'b1;
  end

  always_comb begin
    hidden   = (bus.game_state == GS_END) && frame_cnt[BLINK_LOG2];
    in_box   = bus.pix_valid && !hidden
            && ({1'b0, bus.pix_x} >= 11'(BIRD_X))
            && ({1'b0, bus.pix_x} <  11'(BIRD_X + BIRD_SIZE_X))
            && ({1'b0, bus.pix_y} >= {1'b0, lat_y})
            && ({1'b0, bus.pix_y} <  ({1'b0, lat_y} + 11'(BIRD_SIZE_Y)));
    col      = ROM_AW'(bus.pix_x) - ROM_AW'(BIRD_X);
    row      = ROM_AW'(bus.pix_y) - ROM_AW'(lat_y);
    // Sprite frames are stored angle-major, three flap phases per angle.
    pose_idx = ROM_AW'(lat_angle) * ROM_AW'(3) + ROM_AW'(lat_state);
    addr_nxt = pose_idx * ROM_AW'(BIRD_SIZE_X * BIRD_SIZE_Y)
             + row * ROM_AW'(BIRD_SIZE_X) + col;
    s2_hit   = s2_in_box && (bus.rom_data != TRANSPARENT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_in_box       <= 1'b0;
      bus.rom_addr    <= '0;
      s2_valid        <= 1'b0;
      s2_in_box       <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.bird_opaque <= 1'b0;
      bus.bird_rgb    <= '0;
    end else begin
      s1_valid        <= bus.pix_valid;
      s1_in_box       <= in_box;
      bus.rom_addr    <= in_box ? addr_nxt : '0;
      s2_valid        <= s1_valid;
      s2_in_box       <= s1_in_box;
      bus.out_valid   <= s2_valid;
      bus.bird_opaque <= s2_hit;
      bus.bird_rgb    <= s2_hit ? bus.rom_data : '0;
    end
  end

endmodule
